// File: rtl/fnd_pkg.sv
// Shared constants for the seven-segment scan driver: segment patterns
// (active-high, {g,f,e,d,c,b,a}) and digit-index encoding.
package fnd_pkg;

  localparam logic [6:0] SEG_0    = 7'b0111111;
  localparam logic [6:0] SEG_1    = 7'b0000110;
  localparam logic [6:0] SEG_2    = 7'b1011011;
  localparam logic [6:0] SEG_3    = 7'b1001111;
  localparam logic [6:0] SEG_4    = 7'b1100110;
  localparam logic [6:0] SEG_5    = 7'b1101101;
  localparam logic [6:0] SEG_6    = 7'b1111101;
  localparam logic [6:0] SEG_7    = 7'b0000111;
  localparam logic [6:0] SEG_8    = 7'b1111111;
  localparam logic [6:0] SEG_9    = 7'b1101111;
  localparam logic [6:0] SEG_DASH = 7'b1000000;

  localparam logic [1:0] DIG_SEC_ONES = 2'd0;
  localparam logic [1:0] DIG_SEC_TENS = 2'd1;
  localparam logic [1:0] DIG_MIN_ONES = 2'd2;
  localparam logic [1:0] DIG_MIN_TENS = 2'd3;

  typedef struct packed {
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
  } bcd_time_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// BCD digit to active-high seven-segment pattern; non-BCD codes show a dash.
module bcd_to_seg7
  import fnd_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/fnd_scan_driver.sv
// Time-multiplexed 4-digit FND driver. Digits are snapshotted once per frame
// so a frame never mixes old and new time; all pin outputs are registered.
module fnd_scan_driver
  import fnd_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter bit          SEG_ACT_HIGH = 1'b1,
  parameter bit          DIG_ACT_HIGH = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] in_min_tens,
  input  logic [3:0] in_min_ones,
  input  logic [3:0] in_sec_tens,
  input  logic [3:0] in_sec_ones,
  input  logic       colon,
  input  logic       lz_blank,
  input  logic       blank,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] dig_sel,
  output logic       frame_done
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [6:0] SEG_INV = {7{~SEG_ACT_HIGH}};
  localparam logic [3:0] DIG_INV = {4{~DIG_ACT_HIGH}};

  logic [PW-1:0] presc;
  logic [1:0]    idx;
  bcd_time_t     snap;
  logic          tick, wrap;
  logic [3:0]    cur_digit;
  logic [6:0]    dec_seg, seg_n;
  logic          dp_n;
  logic [3:0]    dig_n;

  assign tick = (presc == PW'(SCAN_DIV - 1));
  assign wrap = tick && (idx == DIG_MIN_TENS);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc      <= '0;
      idx        <= DIG_SEC_ONES;
      snap       <= '0;
      frame_done <= 1'b0;
    end else begin
      presc      <= tick ? '0 : presc + PW'(1);
      frame_done <= wrap;
      if (tick) idx <= idx + 2'd1;
      if (wrap) snap <= '{min_tens: in_min_tens, min_ones: in_min_ones,
                          sec_tens: in_sec_tens, sec_ones: in_sec_ones};
    end
  end

  always_comb begin
    cur_digit = snap.sec_ones;
    case (idx)
      DIG_SEC_ONES: cur_digit = snap.sec_ones;
      DIG_SEC_TENS: cur_digit = snap.sec_tens;
      DIG_MIN_ONES: cur_digit = snap.min_ones;
      DIG_MIN_TENS: cur_digit = snap.min_tens;
      default:      cur_digit = snap.sec_ones;
    endcase
  end

  bcd_to_seg7 u_dec (
    .bcd (cur_digit),
    .seg (dec_seg)
  );

  // Active-high view of the next pin state; polarity is applied at the register.
  always_comb begin
    seg_n = dec_seg;
    dp_n  = colon && (idx == DIG_MIN_ONES);
    dig_n = 4'b0001 << idx;
    if (lz_blank && (idx == DIG_MIN_TENS) && (snap.min_tens == 4'd0)) seg_n = '0;
    if (blank) begin
      seg_n = '0;
      dp_n  = 1'b0;
      dig_n = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      seg     <= SEG_INV;
      dp      <= ~SEG_ACT_HIGH;
      dig_sel <= DIG_INV;
    end else begin
      seg     <= seg_n ^ SEG_INV;
      dp      <= dp_n ^ ~SEG_ACT_HIGH;
      dig_sel <= dig_n ^ DIG_INV;
    end
  end

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Bench for fnd_scan_driver: an active-high and an inverted-polarity instance
// share stimulus and are compared against a cycle-count based reference.
module tb_fnd_scan_driver;

  localparam int SD = 4;
  localparam int FR = 4 * SD;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] mt = 4'd4, mo = 4'd3, st = 4'd2, so = 4'd1;
  logic       colon = 1'b0, lz = 1'b0, blank = 1'b0;

  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b, fd_a, fd_b;
  logic [3:0] dig_a, dig_b;

  int         errors = 0;
  int         checks = 0;
  int         n = 0;
  logic [15:0] snap_m = '0;

  always #5 clock = ~clock;

  fnd_scan_driver #(.SCAN_DIV(SD), .SEG_ACT_HIGH(1'b1), .DIG_ACT_HIGH(1'b1)) dut_a (
    .clock(clock), .reset(reset),
    .in_min_tens(mt), .in_min_ones(mo), .in_sec_tens(st), .in_sec_ones(so),
    .colon(colon), .lz_blank(lz), .blank(blank),
    .seg(seg_a), .dp(dp_a), .dig_sel(dig_a), .frame_done(fd_a)
  );

  fnd_scan_driver #(.SCAN_DIV(SD), .SEG_ACT_HIGH(1'b0), .DIG_ACT_HIGH(1'b0)) dut_b (
    .clock(clock), .reset(reset),
    .in_min_tens(mt), .in_min_ones(mo), .in_sec_tens(st), .in_sec_ones(so),
    .colon(colon), .lz_blank(lz), .blank(blank),
    .seg(seg_b), .dp(dp_b), .dig_sel(dig_b), .frame_done(fd_b)
  );

  function automatic logic [6:0] pat(input logic [3:0] d);
    case (d)
      4'd0: return 7'b0111111;
      4'd1: return 7'b0000110;
      4'd2: return 7'b1011011;
      4'd3: return 7'b1001111;
      4'd4: return 7'b1100110;
      4'd5: return 7'b1101101;
      4'd6: return 7'b1111101;
      4'd7: return 7'b0000111;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1101111;
      default: return 7'b1000000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b edge=%0d", tag, obs, exp, n);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_seg_a"}, {1'b0, seg_a}, 8'h00);
    check({tag, "_dp_a"},  {7'b0, dp_a},  8'h00);
    check({tag, "_dig_a"}, {4'b0, dig_a}, 8'h00);
    check({tag, "_fd_a"},  {7'b0, fd_a},  8'h00);
    check({tag, "_seg_b"}, {1'b0, seg_b}, 8'h7f);
    check({tag, "_dp_b"},  {7'b0, dp_b},  8'h01);
    check({tag, "_dig_b"}, {4'b0, dig_b}, 8'h0f);
    check({tag, "_fd_b"},  {7'b0, fd_b},  8'h00);
  endtask

  // One clock: outputs after edge n+1 show the digit lit during cycle n
  // (index = n/SD mod 4) from the snapshot taken at the last frame boundary.
  task automatic step(input string tag);
    int         idx;
    logic [3:0] d;
    logic [6:0] e_seg;
    logic       e_dp, e_fd;
    logic [3:0] e_dig;
    @(posedge clock);
    idx   = (n / SD) % 4;
    d     = snap_m[idx*4 +: 4];
    e_seg = pat(d);
    if (lz && idx == 3 && d == 4'd0) e_seg = '0;
    e_dp  = colon && idx == 2;
    e_dig = 4'(1 << idx);
    if (blank) begin
      e_seg = '0;
      e_dp  = 1'b0;
      e_dig = '0;
    end
    n++;
    e_fd = (n % FR == 0);
    if (n % FR == 0) snap_m = {mt, mo, st, so};
    @(negedge clock);
    check({tag, "_seg_a"}, {1'b0, seg_a}, {1'b0, e_seg});
    check({tag, "_dp_a"},  {7'b0, dp_a},  {7'b0, e_dp});
    check({tag, "_dig_a"}, {4'b0, dig_a}, {4'b0, e_dig});
    check({tag, "_fd_a"},  {7'b0, fd_a},  {7'b0, e_fd});
    check({tag, "_seg_b"}, {1'b0, seg_b}, {1'b0, ~e_seg});
    check({tag, "_dp_b"},  {7'b0, dp_b},  {7'b0, ~e_dp});
    check({tag, "_dig_b"}, {4'b0, dig_b}, {4'b0, ~e_dig});
    check({tag, "_fd_b"},  {7'b0, fd_b},  {7'b0, e_fd});
  endtask

  function automatic logic [3:0] rnd_digit();
    if ($urandom_range(0, 7) == 0) return 4'($urandom_range(10, 15));
    return 4'($urandom_range(0, 9));
  endfunction

  initial begin
    #1 reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      check_reset("in_reset");
    end
    reset = 1'b1;
    n = 0;
    snap_m = '0;

    repeat (FR) step("first_frame");
    repeat (6) step("frame2_pre");
    so = 4'd9;
    repeat (FR + 10) step("mid_change");

    mt = 4'd0; lz = 1'b1; st = 4'd12; colon = 1'b1;
    repeat (2 * FR) step("lz_err_colon");

    blank = 1'b1;
    repeat (10) step("blank");
    blank = 1'b0;
    repeat (FR + 4) step("unblank");

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        mt = rnd_digit(); mo = rnd_digit(); st = rnd_digit(); so = rnd_digit();
      end
      if ($urandom_range(0, 7) == 0) colon = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) lz = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) blank = 1'($urandom_range(0, 1));
      step("random");
    end
    blank = 1'b0;
    repeat (7) step("pre_reset");

    // Asynchronous reset taken between clock edges.
    #2 reset = 1'b0;
    #1 check_reset("async_reset");
    @(negedge clock);
    check_reset("async_reset_hold");
    reset = 1'b1;
    n = 0;
    snap_m = '0;
    repeat (2 * FR + 3) step("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
